// File: rtl/sonic_pkg.sv
// Shared definitions for the sonar ping path: controller states, physical
// constants and the default timing for a 100 MHz clock and 40 kHz transducer.
package sonic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    LISTEN = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ              = 100_000_000;
  localparam int unsigned TX_FREQ_HZ          = 40_000;
  localparam int unsigned SPEED_OF_SOUND_CM_S = 34300;

  localparam int unsigned DEF_TX_HALF_PERIOD = CLK_HZ / TX_FREQ_HZ / 2;
  localparam int unsigned DEF_BURST_CYCLES   = 8;
  localparam int unsigned DEF_BLANK_CYCLES   = 25_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 125_000;
  localparam int unsigned DEF_DEBOUNCE       = 3;
  localparam int unsigned DEF_PING_INTERVAL  = CLK_HZ / 20;

  // The range stage multiplies the count by the speed of sound in 32 bits.
  function automatic bit range_fits(input longint unsigned max_count);
    return (max_count * longint'(SPEED_OF_SOUND_CM_S)) < 64'h1_0000_0000;
  endfunction

endpackage

// File: rtl/rx_conditioner.sv
// Comparator echo conditioning: two-flop synchroniser followed by a debounce
// counter that only advances while enabled; emits a one-cycle accept pulse.
module rx_conditioner
  import sonic_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rx_in,
  input  logic en,
  output logic accept
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);

  logic          sync_a;
  logic          sync_b;
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      // NOTE: non-blocking so sync_b takes the old sync_a; blocking here would
      // collapse the two flops into one and defeat the synchroniser.
      sync_a <= rx_in;
      sync_b <= sync_a;
      if (!sync_b) begin
        deb_cnt <= '0;
      end else if (en && (deb_cnt != DEB_MAX)) begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Saturating at DEBOUNCE keeps a held-high echo from re-triggering.
  assign accept = en && sync_b && (deb_cnt == DEB_LAST);

endmodule

// File: rtl/echo_timer.sv
// Sonar ping controller: emits the 40 kHz burst, times the echo from burst
// start and presents a frozen time-of-flight count with a level echo flag.
module echo_timer
  import sonic_pkg::*;
#(
  parameter int unsigned TX_HALF_PERIOD = DEF_TX_HALF_PERIOD,
  parameter int unsigned BURST_CYCLES   = DEF_BURST_CYCLES,
  parameter int unsigned BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned DEBOUNCE       = DEF_DEBOUNCE,
  parameter int unsigned PING_INTERVAL  = DEF_PING_INTERVAL
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        trigger_in,
  input  logic        auto_en_in,
  input  logic        rx_in,
  output logic        tx_out,
  output logic [31:0] time_since_emission,
  output logic        echo_detected,
  output logic        timeout_out,
  output logic        busy_out
);

  if (BLANK_CYCLES >= TIMEOUT_CYCLES) begin : g_chk_blank
    $error("echo_timer: BLANK_CYCLES must be below TIMEOUT_CYCLES");
  end
  if (DEBOUNCE < 1) begin : g_chk_debounce
    $error("echo_timer: DEBOUNCE must be at least 1");
  end
  if (TX_HALF_PERIOD < 1) begin : g_chk_half
    $error("echo_timer: TX_HALF_PERIOD must be at least 1");
  end
  if (BURST_CYCLES < 1) begin : g_chk_burst
    $error("echo_timer: BURST_CYCLES must be at least 1");
  end
  if (!range_fits(longint'(TIMEOUT_CYCLES))) begin : g_chk_range
    $error("echo_timer: TIMEOUT_CYCLES overflows the 32-bit range product");
  end

  localparam int unsigned HCW = $clog2(TX_HALF_PERIOD + 1);
  localparam int unsigned HIW = $clog2(2 * BURST_CYCLES + 1);
  localparam int unsigned IW  = $clog2(PING_INTERVAL + 1);

  localparam logic [HCW-1:0] HALF_LAST   = HCW'(TX_HALF_PERIOD - 1);
  localparam logic [HIW-1:0] HALVES_LAST = HIW'(2 * BURST_CYCLES - 1);
  localparam logic [IW-1:0]  INT_LAST    = IW'(PING_INTERVAL - 1);
  localparam logic [31:0]    BLANK_CNT   = 32'(BLANK_CYCLES);
  localparam logic [31:0]    LAST_CNT    = 32'(TIMEOUT_CYCLES - 1);

  state_t         state;
  logic [HCW-1:0] half_cnt;
  logic [HIW-1:0] half_idx;
  logic [IW-1:0]  interval_cnt;
  logic           accept;
  logic           auto_due;
  logic           start;

  rx_conditioner #(
    .DEBOUNCE (DEBOUNCE)
  ) u_rx (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rx_in  (rx_in),
    .en     (time_since_emission >= BLANK_CNT),
    .accept (accept)
  );

  assign auto_due = auto_en_in && (interval_cnt >= INT_LAST);
  assign start    = (state == IDLE) && (trigger_in || auto_due);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= IDLE;
      half_cnt            <= '0;
      half_idx            <= '0;
      interval_cnt        <= '0;
      tx_out              <= 1'b0;
      time_since_emission <= '0;
      echo_detected       <= 1'b0;
      timeout_out         <= 1'b0;
      busy_out            <= 1'b0;
    end else begin
      // NOTE: default-low each cycle, so only the timeout branch can raise it
      // and it can never stay high longer than one cycle.
      timeout_out <= 1'b0;

      if (start) begin
        interval_cnt <= '0;
      end else if (interval_cnt != INT_LAST) begin
        interval_cnt <= interval_cnt + IW'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state               <= BURST;
            half_cnt            <= '0;
            half_idx            <= '0;
            tx_out              <= 1'b1;
            time_since_emission <= '0;
            echo_detected       <= 1'b0;
            busy_out            <= 1'b1;
          end
        end

        BURST: begin
          time_since_emission <= time_since_emission + 32'd1;
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (half_idx == HALVES_LAST) begin
              state  <= LISTEN;
              tx_out <= 1'b0;
            end else begin
              half_idx <= half_idx + HIW'(1);
              tx_out   <= ~tx_out;
            end
          end else begin
            half_cnt <= half_cnt + HCW'(1);
          end
        end

        LISTEN: begin
          // Capture or timeout leaves the count untouched, freezing it.
          if (accept) begin
            state         <= IDLE;
            echo_detected <= 1'b1;
            busy_out      <= 1'b0;
          end else if (time_since_emission >= LAST_CNT) begin
            state       <= IDLE;
            timeout_out <= 1'b1;
            busy_out    <= 1'b0;
          end else begin
            time_since_emission <= time_since_emission + 32'd1;
          end
        end

        default: begin
          state    <= IDLE;
          tx_out   <= 1'b0;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/echo_timer.md
Name: echo_timer

Overview:
Front-end ping controller for the sonar range path. It emits a 40 kHz transducer burst and counts clock cycles from the start of emission. It conditions the comparator echo input (synchroniser plus debounce, gated by a blanking window) and presents a frozen time-of-flight count with a level echo flag. The time-of-flight-to-range stage downstream consumes the count on the rising edge of echo_detected.

Parameters:
TX_HALF_PERIOD, 1250, clk cycles per half period of the tx square wave (100 MHz / 40 kHz / 2)
BURST_CYCLES, 8, full tx periods per ping
BLANK_CYCLES, 25000, count below which rx is ignored (covers burst ring-down)
TIMEOUT_CYCLES, 125000, max listen count; keeps 34300*count < 2^32 for the range stage
DEBOUNCE, 3, consecutive synced-high samples required to accept an echo
PING_INTERVAL, 5000000, cycles between auto pings (50 ms)

Ports:
clk_in  input  1  system clock, 100 MHz
rst_in  input  1  synchronous, active-high reset
trigger_in  input  1  single-cycle request for one ping
auto_en_in  input  1  when high, pings every PING_INTERVAL cycles
rx_in  input  1  asynchronous comparator output from receive transducer
tx_out  output  1  transducer drive square wave
time_since_emission  output  32  cycles since burst start; frozen at capture or timeout
echo_detected  output  1  level; high from echo capture until next ping start
timeout_out  output  1  one-cycle pulse when listen window expires with no echo
busy_out  output  1  high in BURST and LISTEN

Behaviour:
- Reset values: tx_out=0, time_since_emission=0, echo_detected=0, timeout_out=0, busy_out=0, state=IDLE, sync/debounce/interval counters=0. Reset mid-operation aborts the ping: tx_out is 0 after the reset edge, and no capture or timeout is reported.
- States: IDLE, BURST, LISTEN.
- IDLE -> BURST when trigger_in=1, or when auto_en_in=1 and interval_cnt >= PING_INTERVAL-1.
  - On that edge: time_since_emission<=0, echo_detected<=0, interval_cnt<=0, tx_out<=1, busy_out<=1.
  - trigger_in and an auto request in the same cycle produce one ping.
  - trigger_in while busy is ignored, not queued.
- interval_cnt increments every cycle from ping start and saturates at PING_INTERVAL-1. An auto request that comes due while busy fires on the first IDLE cycle.
- BURST:
  - tx_out toggles every TX_HALF_PERIOD cycles, starting high, for 2*BURST_CYCLES half periods.
  - After the last low half ends, the block enters LISTEN and tx_out stays 0.
  - time_since_emission increments by 1 each cycle; its value is 0 in the first BURST cycle.
- LISTEN: time_since_emission continues incrementing.
- rx path:
  - 2-FF synchroniser feeds a debounce counter. The counter resets on any synced-low sample and counts only while time_since_emission >= BLANK_CYCLES.
  - Capture when the debounce count reaches DEBOUNCE. Latency from the first edge sampling rx_in high (at count N) to capture is 2+DEBOUNCE-1 cycles.
  - Capture is done by the rx path, but is acted on only in LISTEN (see below).
- Capture (LISTEN only):
  - echo_detected<=1 on the same edge that time_since_emission freezes at N+2+DEBOUNCE-1, so the count is valid in the first cycle echo_detected is high.
  - Next state is IDLE, busy_out<=0.
  - echo_detected and the count are held until the next ping start.
- Echo debounce completing during BURST with count >= BLANK_CYCLES is ignored. BLANK_CYCLES >= burst length is the intended configuration.
- Timeout: in LISTEN, with no capture, the count reaches TIMEOUT_CYCLES-1.
  - Response: timeout_out=1 for exactly one cycle, count frozen at TIMEOUT_CYCLES-1, echo_detected stays 0, next state IDLE.
  - Capture and timeout in the same cycle: capture wins and timeout_out stays 0.
- Counter width is 32 bits; the count never wraps because it is bounded by the timeout.
- Elaboration checks: BLANK_CYCLES < TIMEOUT_CYCLES, DEBOUNCE >= 1, TX_HALF_PERIOD >= 1, BURST_CYCLES >= 1, TIMEOUT_CYCLES*34300 < 2^32.

Decomposition:
- Shared package sonic_pkg: state enum (IDLE, BURST, LISTEN), CLK_HZ=100_000_000, TX_FREQ_HZ=40_000, SPEED_OF_SOUND_CM_S=34300, default timing constants.
- One sub-module, rx_conditioner: 2-FF sync plus debounce with enable input; outputs a one-cycle accept pulse.

Test Plan (sim params TX_HALF_PERIOD=2, BURST_CYCLES=2, BLANK_CYCLES=20, TIMEOUT_CYCLES=100, DEBOUNCE=3, PING_INTERVAL=150):
1. trigger_in pulse from IDLE -> tx_out sequence 1,1,0,0,1,1,0,0 then 0; busy_out=1; count 0..7 during burst.
2. rx_in first sampled high at count 40 and held -> echo_detected rises with time_since_emission=44; both held; busy_out=0.
3. No rx activity -> timeout_out single pulse with count=99; echo_detected=0; IDLE next cycle.
4. rx_in high for counts 5..15 only (blanking) -> no capture; timeout at 99. rx_in high 2 cycles at 50, then held from 60 -> glitch rejected, capture at 64.
5. auto_en_in=1 with no trigger -> ping starts every 150 cycles. trigger_in mid-LISTEN is ignored. echo_detected clears on the next burst start.
6. rst_in asserted during BURST -> all outputs 0 after that edge; a trigger after release starts a clean ping from count 0.
